picmicro_hw_stack_param: RTL

Parametrised hardware return stack for the midrange core, replacing the fixed 8x13 stack inside the program-counter unit. It holds return addresses for call/return/retlw and interrupt entry, with configurable width and depth. Overflow handling is selectable: PIC16-style circular wrap, or saturate-and-lock. It adds sticky overflow/underflow flags, a stack-error strobe (STVREN-style reset request) and a single-cycle replace operation (push and pop together).

---
 rtl/picmicro_pkg.sv | 18 +
 rtl/picmicro_hw_stack_param_if.sv | 32 +++
 rtl/picmicro_stack_ptr.sv | 37 +++
 rtl/picmicro_hw_stack_param.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/picmicro_pkg.sv
// Shared types and defaults for the midrange core's hardware return stack.
package picmicro_pkg;

    // Policy applied when a push arrives while every entry is occupied.
    typedef enum logic {
        STK_WRAP = 1'b0,   // overwrite the oldest entry, like the classic PIC16 stack
        STK_SAT  = 1'b1    // drop the push and keep the existing contents
    } stack_ovf_mode_t;

    localparam int PC_WIDTH            = 13;
    localparam int STACK_DEPTH_DEFAULT = 8;

    // Pointer width for a modulo-depth index; never narrower than one bit.
    function automatic int stack_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/picmicro_hw_stack_param_if.sv
// Bundle between the program-counter unit (master) and the return stack (slave).
interface picmicro_hw_stack_param_if
    import picmicro_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = STACK_DEPTH_DEFAULT
);
    localparam int TW = $clog2(DEPTH + 1);

    logic             push_en;
    logic             pop_en;
    logic [WIDTH-1:0] push_data;
    logic             clr_flags;
    logic [WIDTH-1:0] out;
    logic [TW-1:0]    tos;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;
    logic             stk_err;

    modport master (
        output push_en, pop_en, push_data, clr_flags,
        input  out, tos, empty, full, overflow, underflow, stk_err
    );

    modport slave (
        input  push_en, pop_en, push_data, clr_flags,
        output out, tos, empty, full, overflow, underflow, stk_err
    );

endinterface

// File: rtl/picmicro_stack_ptr.sv
// Modulo-DEPTH up/down pointer; wraps explicitly so DEPTH need not be a power of two.
module picmicro_stack_ptr
    import picmicro_pkg::*;
#(
    parameter  int DEPTH = STACK_DEPTH_DEFAULT,
    localparam int PW    = stack_ptr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [PW-1:0] ptr,
    output logic [PW-1:0] ptr_prev
);

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [PW-1:0] ptr_next;

    // Neighbouring slots of the current pointer, wrapping at both ends.
    always_comb begin
        ptr_next = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        ptr_prev = (ptr == '0) ? PTR_LAST : ptr - 1'b1;
    end

    // Pointer register; simultaneous inc and dec cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc && !dec) begin
            ptr <= ptr_next;
        end else if (dec && !inc) begin
            ptr <= ptr_prev;
        end
    end

endmodule

// File: rtl/picmicro_hw_stack_param.sv
// Parametrised return stack: push/pop/replace with selectable overflow policy,
// sticky overflow/underflow flags and a registered stack-error strobe.
module picmicro_hw_stack_param
    import picmicro_pkg::*;
#(
    parameter int              WIDTH    = PC_WIDTH,
    parameter int              DEPTH    = STACK_DEPTH_DEFAULT,
    parameter stack_ovf_mode_t OVF_MODE = STK_WRAP
) (
    input logic                     clk,
    input logic                     rst,
    picmicro_hw_stack_param_if.slave bus
);

    localparam int              PW      = stack_ptr_width(DEPTH);
    localparam int              TW      = $clog2(DEPTH + 1);
    localparam logic [TW-1:0]   TOS_MAX = TW'(DEPTH);

    logic [WIDTH-1:0] stack [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    wp_prev;
    logic [TW-1:0]    tos;
    logic             overflow;
    logic             underflow;
    logic             stk_err;

    logic             is_empty;
    logic             is_full;
    logic             wr_en;
    logic [PW-1:0]    wr_addr;
    logic             ptr_inc;
    logic             ptr_dec;
    logic             tos_inc;
    logic             tos_dec;
    logic             ovf_evt;
    logic             unf_evt;

    assign is_empty = (tos == '0);
    assign is_full  = (tos == TOS_MAX);

    picmicro_stack_ptr #(
        .DEPTH (DEPTH)
    ) u_wp (
        .clk      (clk),
        .rst      (rst),
        .inc      (ptr_inc),
        .dec      (ptr_dec),
        .ptr      (wp),
        .ptr_prev (wp_prev)
    );

    // Decode the push/pop request against the current occupancy.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = wp;
        ptr_inc = 1'b0;
        ptr_dec = 1'b0;
        tos_inc = 1'b0;
        tos_dec = 1'b0;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (bus.push_en && bus.pop_en) begin
            if (is_empty) begin
                // Nothing to replace: treat as a push but still report the bad pop.
                wr_en   = 1'b1;
                ptr_inc = 1'b1;
                tos_inc = 1'b1;
                unf_evt = 1'b1;
            end else begin
                // Replace the top entry in place; legal even when full.
                wr_en   = 1'b1;
                wr_addr = wp_prev;
            end
        end else if (bus.push_en) begin
            if (!is_full) begin
                wr_en   = 1'b1;
                ptr_inc = 1'b1;
                tos_inc = 1'b1;
            end else begin
                ovf_evt = 1'b1;
                if (OVF_MODE == STK_WRAP) begin
                    // Slot at wp holds the oldest entry once full.
                    wr_en   = 1'b1;
                    ptr_inc = 1'b1;
                end
            end
        end else if (bus.pop_en) begin
            if (!is_empty) begin
                ptr_dec = 1'b1;
                tos_dec = 1'b1;
            end else begin
                unf_evt = 1'b1;
            end
        end
    end

    // Entry storage; popped entries are left in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else if (wr_en) begin
            stack[wr_addr] <= bus.push_data;
        end
    end

    // Occupancy counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            tos <= '0;
        end else if (tos_inc) begin
            tos <= tos + 1'b1;
        end else if (tos_dec) begin
            tos <= tos - 1'b1;
        end
    end

    // Sticky flags and error strobe; a new event beats clr_flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            stk_err   <= 1'b0;
        end else begin
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (bus.clr_flags) begin
                overflow <= 1'b0;
            end
            if (unf_evt) begin
                underflow <= 1'b1;
            end else if (bus.clr_flags) begin
                underflow <= 1'b0;
            end
            stk_err <= ovf_evt | unf_evt;
        end
    end

    assign bus.out       = is_empty ? '0 : stack[wp_prev];
    assign bus.tos       = tos;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = overflow;
    assign bus.underflow = underflow;
    assign bus.stk_err   = stk_err;

endmodule
